// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package seq_mult_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  // Booth decode on {Q[0], Q_-1}
  localparam logic [1:0] BOOTH_NOP = 2'b00;
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  function automatic int cnt_w_calc(input int width);
    return $clog2(width + 2);
  endfunction
endpackage

// File: rtl/seq_booth_datapath.sv
// A/Q/M/Q_-1 registers, Booth add/sub-and-shift, and held product registers.
module seq_booth_datapath
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 25
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_capture,
  input  logic             i_clear,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_m,
  input  logic [WIDTH-1:0] i_q,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);
  localparam int W1 = WIDTH + 1;

  logic [W1-1:0]   r_a, r_q, r_m;
  logic            r_qm1;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic [W1-1:0]   w_sum;
  logic [2*W1:0]   w_shift;
  logic [W1-1:0]   w_m_ext, w_q_ext;

  // One extra bit lets a single signed Booth datapath cover unsigned operands too.
  assign w_m_ext = {i_signed & i_m[WIDTH-1], i_m};
  assign w_q_ext = {i_signed & i_q[WIDTH-1], i_q};

  always_comb begin
    w_sum = r_a;
    case ({r_q[0], r_qm1})
      BOOTH_ADD: w_sum = r_a + r_m;
      BOOTH_SUB: w_sum = r_a - r_m;
      BOOTH_NOP: w_sum = r_a;
      default:   w_sum = r_a;
    endcase
  end

  assign w_shift = {w_sum[W1-1], w_sum, r_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a   <= '0;
      r_q   <= '0;
      r_m   <= '0;
      r_qm1 <= 1'b0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else begin
      if (i_load) begin
        r_a   <= '0;
        r_q   <= w_q_ext;
        r_m   <= w_m_ext;
        r_qm1 <= 1'b0;
      end else if (i_step) begin
        r_a   <= w_shift[2*W1:W1+1];
        r_q   <= w_shift[W1:1];
        r_qm1 <= w_shift[0];
      end
      // Capture takes the post-step value so the final step and result share an edge.
      if (i_clear) begin
        r_hi <= '0;
        r_lo <= '0;
      end else if (i_capture) begin
        {r_hi, r_lo} <= w_shift[2*WIDTH:1];
      end
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;
endmodule

// File: rtl/seq_booth_multiplier.sv
// Sequential radix-2 Booth multiplier: FSM and iteration counter around the datapath.
module seq_booth_multiplier
  import seq_mult_pkg::*;
#(
  parameter int WIDTH      = 25,
  parameter bit EARLY_ZERO = 1'b1,
  parameter int CNT_W      = cnt_w_calc(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] in_m,
  input  logic [WIDTH-1:0] in_q,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out_hi,
  output logic [WIDTH-1:0] out_lo
);
  localparam logic [CNT_W-1:0] W1_CNT = CNT_W'(WIDTH + 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_load, w_step, w_capture, w_clear;
  logic             w_zero_op;

  assign w_zero_op = EARLY_ZERO && ((in_m == '0) || (in_q == '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_capture   = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (r_state == DONE) w_state_nxt = IDLE;
        if (start) begin
          w_load = 1'b1;
          if (w_zero_op) begin
            w_clear     = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_cnt_nxt   = W1_CNT;
            w_state_nxt = CALC;
          end
        end
      end
      CALC: begin
        w_step    = 1'b1;
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_capture   = 1'b1;
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign busy = (r_state == CALC);
  assign done = (r_state == DONE);

  seq_booth_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_step    (w_step),
    .i_capture (w_capture),
    .i_clear   (w_clear),
    .i_signed  (is_signed),
    .i_m       (in_m),
    .i_q       (in_q),
    .o_hi      (out_hi),
    .o_lo      (out_lo)
  );
endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Directed bench: 8-bit (early-zero on/off) and 25-bit multipliers with hand-computed products.
module tb_seq_booth_multiplier;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sgn = 1'b0;
  logic        a_start = 1'b0, b_start = 1'b0, c_start = 1'b0;
  logic [7:0]  m8 = '0, q8 = '0;
  logic [24:0] m25 = '0, q25 = '0;
  logic        a_busy, a_done, b_busy, b_done, c_busy, c_done;
  logic [7:0]  a_hi, a_lo, b_hi, b_lo;
  logic [24:0] c_hi, c_lo;
  int          n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  seq_booth_multiplier #(.WIDTH(8), .EARLY_ZERO(1'b1)) u_a (
    .clk(clk), .reset(rst), .start(a_start), .is_signed(sgn), .in_m(m8), .in_q(q8),
    .busy(a_busy), .done(a_done), .out_hi(a_hi), .out_lo(a_lo));
  seq_booth_multiplier #(.WIDTH(8), .EARLY_ZERO(1'b0)) u_b (
    .clk(clk), .reset(rst), .start(b_start), .is_signed(sgn), .in_m(m8), .in_q(q8),
    .busy(b_busy), .done(b_done), .out_hi(b_hi), .out_lo(b_lo));
  seq_booth_multiplier #(.WIDTH(25)) u_c (
    .clk(clk), .reset(rst), .start(c_start), .is_signed(sgn), .in_m(m25), .in_q(q25),
    .busy(c_busy), .done(c_done), .out_hi(c_hi), .out_lo(c_lo));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start one op on the selected 8-bit DUT; lat = edges after accept until done (-1 on timeout).
  task automatic run8(input bit use_b, input logic [7:0] m, input logic [7:0] q, input logic sg,
                      output int lat, output int bcnt);
    m8 = m; q8 = q; sgn = sg;
    if (use_b) b_start = 1'b1; else a_start = 1'b1;
    tick();
    a_start = 1'b0; b_start = 1'b0;
    lat = -1; bcnt = 0;
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) tick();
      if (use_b ? b_busy : a_busy) bcnt++;
      if (use_b ? b_done : a_done) begin lat = k; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    n_cmp++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", a_busy); end
    n_cmp++; if (a_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", a_done); end
    n_cmp++; if ({a_hi, a_lo} !== 16'h0) begin n_err++; $display("FAIL reset_out: got %h want 0000", {a_hi, a_lo}); end
    n_cmp++; if ({c_busy, c_done, c_hi, c_lo} !== 52'h0) begin n_err++; $display("FAIL reset_w25: got %h want 0", {c_busy, c_done, c_hi, c_lo}); end
  endtask

  task automatic test_unsigned_max();
    int lat, bc;
    run8(1'b0, 8'hFF, 8'hFF, 1'b0, lat, bc);
    n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL umax_latency: got %0d want 9", lat); end
    n_cmp++; if (bc !== 9) begin n_err++; $display("FAIL umax_busy_cycles: got %0d want 9", bc); end
    n_cmp++; if ({a_hi, a_lo} !== 16'hFE01) begin n_err++; $display("FAIL umax_product: got %h want fe01", {a_hi, a_lo}); end
    tick();
    n_cmp++; if (a_done !== 1'b0) begin n_err++; $display("FAIL umax_done_pulse: got %b want 0", a_done); end
    repeat (3) tick();
    n_cmp++; if ({a_hi, a_lo} !== 16'hFE01) begin n_err++; $display("FAIL umax_hold: got %h want fe01", {a_hi, a_lo}); end
  endtask

  task automatic test_signed();
    int lat, bc;
    run8(1'b0, 8'h80, 8'h80, 1'b1, lat, bc);
    n_cmp++; if ({a_hi, a_lo} !== 16'h4000) begin n_err++; $display("FAIL s_min_min: got %h want 4000", {a_hi, a_lo}); end
    run8(1'b0, 8'hFF, 8'h01, 1'b1, lat, bc);
    n_cmp++; if ({a_hi, a_lo} !== 16'hFFFF) begin n_err++; $display("FAIL s_neg1_x1: got %h want ffff", {a_hi, a_lo}); end
    run8(1'b0, 8'hFF, 8'hFF, 1'b1, lat, bc);
    n_cmp++; if ({a_hi, a_lo} !== 16'h0001) begin n_err++; $display("FAIL s_neg1_neg1: got %h want 0001", {a_hi, a_lo}); end
    run8(1'b0, 8'h7F, 8'h80, 1'b1, lat, bc);
    n_cmp++; if ({a_hi, a_lo} !== 16'hC080) begin n_err++; $display("FAIL s_max_min: got %h want c080", {a_hi, a_lo}); end
    n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL s_latency: got %0d want 9", lat); end
  endtask

  task automatic test_w25();
    int lat = -1, bc = 0;
    m25 = 25'h1000000; q25 = 25'h1000000; sgn = 1'b0; c_start = 1'b1;
    tick();
    c_start = 1'b0;
    for (int k = 0; k <= 60; k++) begin
      if (k > 0) tick();
      if (c_busy) bc++;
      if (c_done) begin lat = k; break; end
    end
    n_cmp++; if (lat !== 26) begin n_err++; $display("FAIL w25_latency: got %0d want 26", lat); end
    n_cmp++; if (bc !== 26) begin n_err++; $display("FAIL w25_busy_cycles: got %0d want 26", bc); end
    n_cmp++; if (c_hi !== 25'h0800000) begin n_err++; $display("FAIL w25_hi: got %h want 0800000", c_hi); end
    n_cmp++; if (c_lo !== 25'h0) begin n_err++; $display("FAIL w25_lo: got %h want 0", c_lo); end
  endtask

  task automatic test_early_zero();
    int lat, bc;
    run8(1'b0, 8'h00, 8'h5A, 1'b0, lat, bc);
    n_cmp++; if (lat !== 0) begin n_err++; $display("FAIL ez_latency: got %0d want 0", lat); end
    n_cmp++; if (bc !== 0) begin n_err++; $display("FAIL ez_busy: got %0d want 0", bc); end
    n_cmp++; if ({a_hi, a_lo} !== 16'h0) begin n_err++; $display("FAIL ez_product: got %h want 0000", {a_hi, a_lo}); end
    tick();
    n_cmp++; if ({a_done, a_busy} !== 2'b00) begin n_err++; $display("FAIL ez_after: got %b want 00", {a_done, a_busy}); end
    run8(1'b1, 8'h00, 8'h5A, 1'b0, lat, bc);
    n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL noez_latency: got %0d want 9", lat); end
    n_cmp++; if ({b_hi, b_lo} !== 16'h0) begin n_err++; $display("FAIL noez_product: got %h want 0000", {b_hi, b_lo}); end
  endtask

  task automatic test_back_to_back();
    int lat = -1;
    m8 = 8'd3; q8 = 8'd5; sgn = 1'b0; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) tick();
      if (k == 4) begin m8 = 8'd7; q8 = 8'd7; a_start = 1'b1; end
      if (k == 5) a_start = 1'b0;
      if (a_done) begin lat = k; break; end
    end
    n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL b2b_first_latency: got %0d want 9", lat); end
    n_cmp++; if ({a_hi, a_lo} !== 16'h000F) begin n_err++; $display("FAIL b2b_ignore_busy_start: got %h want 000f", {a_hi, a_lo}); end
    // Start issued while done is high must be taken.
    m8 = 8'd7; q8 = 8'd7; a_start = 1'b1;
    tick();
    a_start = 1'b0; lat = -1;
    n_cmp++; if (a_busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept_in_done: got busy %b want 1", a_busy); end
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) tick();
      if (k == 4 && a_lo !== 8'h0F) begin n_err++; $display("FAIL b2b_hold_during_calc: got %h want 0f", a_lo); end
      if (k == 4) n_cmp++;
      if (a_done) begin lat = k; break; end
    end
    n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL b2b_second_latency: got %0d want 9", lat); end
    n_cmp++; if ({a_hi, a_lo} !== 16'h0031) begin n_err++; $display("FAIL b2b_second_product: got %h want 0031", {a_hi, a_lo}); end
    tick();
  endtask

  task automatic test_abort_reset();
    int lat, bc, dcnt = 0;
    m8 = 8'hFF; q8 = 8'hFF; sgn = 1'b0; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", a_busy); end
    n_cmp++; if ({a_hi, a_lo} !== 16'h0) begin n_err++; $display("FAIL abort_out: got %h want 0000", {a_hi, a_lo}); end
    for (int k = 0; k < 15; k++) begin
      if (a_done) dcnt++;
      tick();
    end
    n_cmp++; if (dcnt !== 0) begin n_err++; $display("FAIL abort_no_done: got %0d pulses want 0", dcnt); end
    run8(1'b0, 8'h12, 8'h34, 1'b0, lat, bc);
    n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL abort_restart_latency: got %0d want 9", lat); end
    n_cmp++; if ({a_hi, a_lo} !== 16'h03A8) begin n_err++; $display("FAIL abort_restart_product: got %h want 03a8", {a_hi, a_lo}); end
  endtask

  initial begin
    test_reset();
    test_unsigned_max();
    test_signed();
    test_w25();
    test_early_zero();
    test_back_to_back();
    test_abort_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/seq_booth_multiplier.md
Name: seq_booth_multiplier

Overview:
- Parametrised sequential radix-2 Booth multiplier, one Booth step per cycle.
- Next-generation replacement for the fixed 25-bit controller/datapath multiplier used in the floating-point mantissa path.
- Adds a WIDTH parameter, per-operation signed/unsigned mode, a busy/done handshake with held results, and an optional zero-operand early exit.

Parameters:
- WIDTH, 25: operand width in bits; the product is 2*WIDTH bits. Legal range 2..64.
- EARLY_ZERO, 1: when 1, an operation with a zero operand completes in 1 cycle; when 0, every operation takes full latency.
- CNT_W, $clog2(WIDTH+2): iteration counter width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; latched with start.
- in_m  in  WIDTH  multiplicand; latched with start.
- in_q  in  WIDTH  multiplier; latched with start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when the result becomes valid.
- out_hi  out  WIDTH  product bits [2*WIDTH-1:WIDTH].
- out_lo  out  WIDTH  product bits [WIDTH-1:0].

Behaviour:
- Reset (synchronous): state=IDLE, busy=0, done=0, out_hi=0, out_lo=0, counter=0. Reset mid-operation aborts the operation immediately; no done pulse is produced.
- States:
  - IDLE: wait for start.
  - CALC: Booth iterations.
  - DONE: one cycle, done=1.
- Accept: start=1 at a clock edge with state IDLE or DONE (busy=0).
  - Latch operands, mode, A=0, Q_-1=0, counter=W1, where W1=WIDTH+1.
  - Next state is CALC, busy=1.
  - start while busy=1 is ignored; latched operands do not change.
- Internal width W1=WIDTH+1. Operands are sign-extended (is_signed=1) or zero-extended (is_signed=0) to W1. One Booth datapath then serves both modes.
- CALC, each cycle, on {Q[0],Q_-1}:
  - 01: A=A+M
  - 10: A=A-M
  - 00/11: no add
  - Then arithmetic-shift {A,Q,Q_-1} right by 1 and decrement the counter.
  - A and M are W1 bits wide. Add/sub wraps modulo 2^W1.
- When the counter reaches 0, register the product:
  - out_hi = {A,Q}[2*WIDTH-1:WIDTH]
  - out_lo = {A,Q}[WIDTH-1:0]
  - state=DONE, busy=0, done=1.
- Latency: start sampled at edge E0; done=1 in the cycle after edge E_W1 (W1 cycles). Throughput is one operation per W1+1 cycles. A back-to-back start may be issued in the DONE cycle.
- EARLY_ZERO=1 and in_m==0 or in_q==0 at accept:
  - Skip CALC and go IDLE -> DONE directly.
  - out_hi=out_lo=0; done=1 in the cycle after E0.
  - busy stays 0.
- Results hold until the next accepted operation completes or reset. out_* do not change during CALC.
- Signed mode, WIDTH bits: the result is exact, including -2^(WIDTH-1) * -2^(WIDTH-1).
- Unsigned mode: the result is exact for all operand values.

Decomposition:
- Package seq_mult_pkg holds:
  - state enum {IDLE, CALC, DONE}
  - Booth decode localparams (BOOTH_NOP, BOOTH_ADD, BOOTH_SUB)
  - function for the CNT_W calculation
- Split matches the existing controller/datapath structure:
  - Top level holds the FSM and counter.
  - Sub-module seq_booth_datapath holds the A/Q/M/Q_-1 registers, add/sub, shift and extension, with load/step/capture strobes from the FSM.

Test Plan:
- WIDTH=8, unsigned, in_m=0xFF, in_q=0xFF -> done 9 cycles after start, out_hi=0xFE, out_lo=0x01, busy high for exactly 9 cycles.
- WIDTH=8, signed:
  - in_m=0x80, in_q=0x80 -> out_hi=0x40, out_lo=0x00.
  - in_m=0xFF, in_q=0x01 -> out_hi=0xFF, out_lo=0xFF.
- WIDTH=25, unsigned, in_m=in_q=0x1000000 -> out_hi=0x0800000, out_lo=0; latency 26 cycles.
- EARLY_ZERO=1, WIDTH=8, in_m=0x00, in_q=0x5A -> done in the cycle after start, out_hi=out_lo=0, busy never asserted. Repeat with EARLY_ZERO=0 -> done after 9 cycles, result 0.
- Start with 3*5, then pulse start with 7*7 at cycle 4 -> second start ignored; result 15 (out_lo=0x0F). A start in the DONE cycle with 7*7 -> accepted; out_lo=0x31 after 9 more cycles.
- Start with 0xFF*0xFF, assert reset at cycle 5 -> busy=0, done never pulses, out_hi=out_lo=0. A new start after reset deasserts gives the correct result.
